// File: rtl/apb_cmd_requester.sv
// Stream-driven APB requester. Each accepted command runs one APB3/APB4
// transfer. The result comes back on a valid/ready response channel. A
// watchdog aborts ACCESS phases that hang, and a saturating counter tracks
// how many responses came back with an error.
module apb_cmd_requester #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    pclk,
    input  logic                    rst,
    // Command channel
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    // Response channel
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    resp_timeout,
    output logic [15:0]             err_count,
    // APB requester
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;
    localparam int unsigned CntWidth  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          WdogEn    = (TIMEOUT_CYCLES != 0);
    // Counter value on the last ACCESS cycle allowed before the abort.
    localparam logic [CntWidth-1:0] CntLast =
        CntWidth'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [StrbWidth-1:0]  pstrb_q, pstrb_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic                  resp_timeout_q, resp_timeout_d;
    logic [15:0]           err_count_q, err_count_d;

    assign cmd_ready    = (state_q == StIdle) && !rst;
    assign psel         = psel_q;
    assign penable      = penable_q;
    assign pwrite       = pwrite_q;
    assign paddr        = paddr_q;
    assign pwdata       = pwdata_q;
    assign pstrb        = pstrb_q;
    assign pprot        = 3'b010;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign resp_timeout = resp_timeout_q;
    assign err_count    = err_count_q;

    // Next-state logic for the transfer FSM, the APB outputs and the response.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        psel_d         = psel_q;
        penable_d      = penable_q;
        pwrite_d       = pwrite_q;
        paddr_d        = paddr_q;
        pwdata_d       = pwdata_q;
        pstrb_d        = pstrb_q;
        resp_valid_d   = resp_valid_q;
        resp_rdata_d   = resp_rdata_q;
        resp_err_d     = resp_err_q;
        resp_timeout_d = resp_timeout_q;
        err_count_d    = err_count_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    // Reads drive no data and no strobes onto the bus.
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    pstrb_d   = cmd_write ? cmd_wstrb : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = StAccess;
            end
            StAccess: begin
                // A completion seen on the last allowed cycle still wins over the abort.
                if (pready) begin
                    resp_rdata_d   = pwrite_q ? '0 : prdata;
                    resp_err_d     = pslverr;
                    resp_timeout_d = 1'b0;
                    psel_d         = 1'b0;
                    penable_d      = 1'b0;
                    resp_valid_d   = 1'b1;
                    state_d        = StResp;
                end else if (WdogEn && (cnt_q == CntLast)) begin
                    resp_rdata_d   = '0;
                    resp_err_d     = 1'b1;
                    resp_timeout_d = 1'b1;
                    psel_d         = 1'b0;
                    penable_d      = 1'b0;
                    resp_valid_d   = 1'b1;
                    state_d        = StResp;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                    if (resp_err_q && (err_count_q != 16'hffff)) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers. Reset releases the bus and drops any pending response.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            pwrite_q       <= 1'b0;
            paddr_q        <= '0;
            pwdata_q       <= '0;
            pstrb_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_err_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            psel_q         <= psel_d;
            penable_q      <= penable_d;
            pwrite_q       <= pwrite_d;
            paddr_q        <= paddr_d;
            pwdata_q       <= pwdata_d;
            pstrb_q        <= pstrb_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
            resp_timeout_q <= resp_timeout_d;
            err_count_q    <= err_count_d;
        end
    end

endmodule

// File: tb/tb_apb_cmd_requester.sv
// Self-checking bench for apb_cmd_requester: table of single transfers with
// a scoreboard of expected responses, then hand-written corner sequences.
module tb_apb_cmd_requester;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          pclk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          resp_valid, resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err, resp_timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic          pready = 1'b0;
    logic [DW-1:0] prdata = '0;
    logic          pslverr = 1'b0;

    always #5 pclk = ~pclk;

    apb_cmd_requester #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .resp_timeout(resp_timeout),
        .err_count   (err_count),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_lat;
        int          bp;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_errcnt = '0;
    logic        last_err;
    logic [31:0] last_rdata;

    // Completer configuration and expected bus contents for the current command.
    int          cur_waits  = 0;
    logic        cur_slverr = 1'b0;
    logic [31:0] cur_prdata = '0;
    logic        idle_pready = 1'b0;
    int          acc_n = 0;
    logic [31:0] mon_addr = '0, mon_wdata = '0;
    logic        mon_write = 1'b0;
    logic [3:0]  mon_strb = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Completer model: answers on ACCESS cycle index cur_waits; garbage otherwise.
    always @(negedge pclk) begin
        if (psel && penable) begin
            pready  = (acc_n == cur_waits);
            prdata  = (acc_n == cur_waits) ? cur_prdata : 32'h0bad_0bad;
            pslverr = (acc_n == cur_waits) ? cur_slverr : 1'b1;
            acc_n++;
        end else begin
            pready  = idle_pready;
            prdata  = 32'hffff_ffff;
            pslverr = idle_pready;
            acc_n   = 0;
        end
    end

    // Bus protocol monitor.
    always @(negedge pclk) begin
        if (!rst) begin
            if (penable) check("penable_without_psel", {63'd0, psel}, 64'd1);
            if (psel) begin
                check("paddr_stable", {32'd0, paddr}, {32'd0, mon_addr});
                check("pwrite_stable", {63'd0, pwrite}, {63'd0, mon_write});
                check("pwdata_stable", {32'd0, pwdata}, {32'd0, mon_wdata});
                check("pstrb_stable", {60'd0, pstrb}, {60'd0, mon_strb});
            end
            if (resp_valid) check("psel_during_resp", {63'd0, psel}, 64'd0);
        end
    end

    task automatic drive_cmd(input vec_t v);
        exp_t e;
        cur_waits  = v.waits;
        cur_slverr = v.slverr;
        cur_prdata = v.prdata;
        cmd_write  = v.write;
        cmd_addr   = v.addr;
        cmd_wdata  = v.wdata;
        cmd_wstrb  = v.wstrb;
        cmd_valid  = 1'b1;
        mon_addr   = v.addr;
        mon_write  = v.write;
        mon_wdata  = v.write ? v.wdata : 32'd0;
        mon_strb   = v.write ? v.wstrb : 4'd0;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.to    = v.exp_to;
        sb_q.push_back(e);
    endtask

    task automatic accept();
        check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        check("psel_setup", {63'd0, psel}, 64'd1);
        check("penable_setup", {63'd0, penable}, 64'd0);
    endtask

    // Counts edges from the accept edge (=1) until resp_valid appears.
    task automatic wait_resp(input int lat_exp);
        int   n;
        exp_t e;
        n = 1;
        while (!resp_valid && n < 64) begin
            @(posedge pclk);
            #1;
            n++;
        end
        check("resp_latency", 64'(n), 64'(lat_exp));
        check("bus_released", {62'd0, psel, penable}, 64'd0);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got response, expected none");
        end else begin
            e = sb_q.pop_front();
            check("resp_rdata", {32'd0, resp_rdata}, {32'd0, e.rdata});
            check("resp_err", {63'd0, resp_err}, {63'd0, e.err});
            check("resp_timeout", {63'd0, resp_timeout}, {63'd0, e.to});
            last_err   = e.err;
            last_rdata = e.rdata;
        end
    endtask

    task automatic handshake(input int bp);
        repeat (bp) begin
            @(posedge pclk);
            #1;
            check("resp_hold_valid", {63'd0, resp_valid}, 64'd1);
            check("resp_hold_rdata", {32'd0, resp_rdata}, {32'd0, last_rdata});
            check("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge pclk);
        #1;
        resp_ready = 1'b0;
        if (last_err && exp_errcnt != 16'hffff) exp_errcnt++;
        check("resp_valid_clear", {63'd0, resp_valid}, 64'd0);
        check("err_count", {48'd0, err_count}, {48'd0, exp_errcnt});
        check("cmd_ready_after", {63'd0, cmd_ready}, 64'd1);
    endtask

    vec_t vecs[7];
    vec_t va, vb, vr;

    initial begin
        //            wr    addr          wdata         strb  wt   serr  prdata        exp_rdata     err   to    lat bp
        vecs[0] = '{1'b1, 32'h0000_0400, 32'hdead_beef, 4'hf, 0,   1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 3,  0};
        vecs[1] = '{1'b0, 32'h0000_1000, 32'hffff_ffff, 4'hf, 3,   1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 6,  0};
        vecs[2] = '{1'b0, 32'h0000_1004, 32'h0,        4'h0, 0,   1'b1, 32'hcafe_f00d, 32'hcafe_f00d, 1'b1, 1'b0, 3,  0};
        vecs[3] = '{1'b0, 32'h0000_1008, 32'h0,        4'h0, 255, 1'b0, 32'h7777_7777, 32'h0,        1'b1, 1'b1, 10, 0};
        vecs[4] = '{1'b1, 32'h0000_100c, 32'ha5a5_5a5a, 4'h5, 1,   1'b1, 32'h9999_9999, 32'h0,        1'b1, 1'b0, 4,  0};
        vecs[5] = '{1'b0, 32'h0000_1010, 32'h0,        4'h0, 7,   1'b0, 32'h0f0f_f0f0, 32'h0f0f_f0f0, 1'b0, 1'b0, 10, 0};
        vecs[6] = '{1'b1, 32'h0000_1014, 32'h3141_5926, 4'ha, 2,   1'b0, 32'h8888_8888, 32'h0,        1'b0, 1'b0, 5,  3};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_psel", {63'd0, psel}, 64'd0);
        check("rst_penable", {63'd0, penable}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_err_count", {48'd0, err_count}, 64'd0);
        check("rst_paddr_pwdata", {paddr, pwdata}, 64'd0);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("pprot", {61'd0, pprot}, 64'd2);
        rst = 1'b0;
        #1;
        check("cmd_ready_out_of_rst", {63'd0, cmd_ready}, 64'd1);
        @(posedge pclk);
        #1;

        for (int i = 0; i < 7; i++) begin
            drive_cmd(vecs[i]);
            accept();
            wait_resp(vecs[i].exp_lat);
            handshake(vecs[i].bp);
        end

        // pready/pslverr pulsed while idle must be ignored.
        idle_pready = 1'b1;
        repeat (3) begin
            @(posedge pclk);
            #1;
            check("idle_pready_resp", {63'd0, resp_valid}, 64'd0);
            check("idle_pready_psel", {63'd0, psel}, 64'd0);
            check("idle_pready_errcnt", {48'd0, err_count}, {48'd0, exp_errcnt});
        end
        idle_pready = 1'b0;
        @(posedge pclk);
        #1;

        // Backpressure with the next command already waiting.
        va = '{1'b1, 32'h0000_2000, 32'h1111_2222, 4'hf, 0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3, 0};
        vb = '{1'b0, 32'h0000_2004, 32'h0, 4'h0, 1, 1'b0, 32'h55aa_55aa, 32'h55aa_55aa,
               1'b0, 1'b0, 4, 0};
        drive_cmd(va);
        accept();
        wait_resp(va.exp_lat);
        drive_cmd(vb);
        repeat (5) begin
            @(posedge pclk);
            #1;
            check("b2b_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            check("b2b_psel", {63'd0, psel}, 64'd0);
            check("b2b_resp_valid", {63'd0, resp_valid}, 64'd1);
        end
        resp_ready = 1'b1;
        @(posedge pclk);
        #1;
        resp_ready = 1'b0;
        check("b2b_handshake", {63'd0, resp_valid}, 64'd0);
        check("b2b_cmd_ready_back", {63'd0, cmd_ready}, 64'd1);
        check("b2b_no_psel_yet", {63'd0, psel}, 64'd0);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        check("b2b_second_start", {63'd0, psel}, 64'd1);
        wait_resp(vb.exp_lat);
        handshake(0);

        // Reset on the second wait cycle of ACCESS.
        vr = '{1'b0, 32'h0000_3000, 32'h0, 4'h0, 5, 1'b0, 32'h4444_4444, 32'h4444_4444,
               1'b0, 1'b0, 8, 0};
        drive_cmd(vr);
        accept();
        @(posedge pclk);
        #1;
        @(posedge pclk);
        #1;
        check("pre_reset_penable", {63'd0, penable}, 64'd1);
        check("pre_reset_errcnt", {48'd0, err_count}, 64'd3);
        rst = 1'b1;
        @(posedge pclk);
        #1;
        check("midrst_psel", {63'd0, psel}, 64'd0);
        check("midrst_penable", {63'd0, penable}, 64'd0);
        check("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("midrst_err_count", {48'd0, err_count}, 64'd0);
        sb_q.delete();
        exp_errcnt = '0;
        rst = 1'b0;
        #1;
        check("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        repeat (2) @(posedge pclk);
        #1;
        check("post_rst_idle", {62'd0, psel, resp_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
